ram_fifo_ctrl: RTL and testbench

//  Queue controller placed directly upstream of the 4x8 RAM. It turns push/pop valid-ready

---
 rtl/ram_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// Push/pop handshake front-end for a 4x8 single-port RAM, making it behave as a FIFO.
// Optional sticky error flags are built only when RAM_FIFO_ERR_FLAGS_EN is defined.
module ram_fifo_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 2,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [1:0]    err,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic {PRI_WR, PRI_RD} arb_e;

  arb_e          arb_q, arb_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop_valid_q, pop_valid_d;
  logic [DW-1:0] pop_data_q, pop_data_d;
  logic          wr_elig, rd_elig;
  logic          do_wr, do_rd;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0) && !pop_valid_q;
  assign count     = count_q;
  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;

  assign wr_elig = push_valid && !full;
  assign rd_elig = (count_q != '0) && (!pop_valid_q || pop_ready);

  always_ff @(posedge clk) begin
    if (clr) arb_q <= PRI_WR;
    else     arb_q <= arb_d;
  end

  always_comb begin
    arb_d = arb_q;
    if (do_wr)      arb_d = PRI_RD;
    else if (do_rd) arb_d = PRI_WR;
  end

  // Grants are suppressed during clr so an in-flight push never reaches the RAM.
  always_comb begin
    do_wr      = 1'b0;
    do_rd      = 1'b0;
    if (!clr) begin
      do_wr = wr_elig && (!rd_elig || (arb_q == PRI_WR));
      do_rd = rd_elig && (!wr_elig || (arb_q == PRI_RD));
    end
    push_ready = do_wr;
    ram_rw     = do_wr;
    ram_addr   = do_wr ? wr_ptr_q : rd_ptr_q;
    ram_din    = do_wr ? push_data : '0;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = pop_valid_q;
    pop_data_d  = pop_data_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      count_d     = count_q - 1'b1;
      pop_valid_d = 1'b1;
      pop_data_d  = ram_dout;
    end else if (pop_ready) begin
      pop_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

`ifdef RAM_FIFO_ERR_FLAGS_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (push_valid && full)       err_d[0] = 1'b1;
    if (pop_ready && !pop_valid_q) err_d[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 4x8 RAM attached.
module tb_ram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       clr;
  logic       push_valid, push_ready;
  logic [7:0] push_data;
  logic       pop_valid, pop_ready;
  logic [7:0] pop_data;
  logic [2:0] count;
  logic       full, empty;
  logic [1:0] err;
  logic       ram_rw;
  logic [1:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  logic [7:0] mem [4];
  int unsigned wr_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src[$];

  logic       s_rw, s_full, s_empty, s_pv, s_pr, acc;
  logic [1:0] s_addr, s_err;
  logic [2:0] s_count;
  logic [7:0] s_pd;
  int unsigned s_wrcnt, prev_wrcnt;

  ram_fifo_ctrl #(.DW(8), .AW(2), .DEPTH(4)) dut (
    .clk(clk), .clr(clr),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count), .full(full), .empty(empty), .err(err),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rw) begin
      mem[ram_addr] <= ram_din;
      wr_cnt        <= wr_cnt + 1;
    end
  end
  assign ram_dout = mem[ram_addr];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (!clr) begin
      if (push_valid && push_ready) exp_q.push_back(push_data);
      if (pop_valid && pop_ready) begin
        n_pops++;
        if (exp_q.size() == 0) chk("pop_without_push", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pop_data", int'(pop_data), int'(e));
        end
      end
    end
  end

  task automatic drive();
    push_valid = (src.size() != 0);
    push_data  = (src.size() != 0) ? src[0] : 8'h00;
  endtask

  task automatic tick();
    @(negedge clk);
    s_rw = ram_rw; s_addr = ram_addr; s_count = count; s_full = full;
    s_empty = empty; s_pv = pop_valid; s_pd = pop_data; s_pr = push_ready;
    s_err = err; s_wrcnt = wr_cnt;
    acc = push_valid && push_ready;
    @(posedge clk); #1;
    if (acc && src.size() != 0) void'(src.pop_front());
    drive();
  endtask

  task automatic do_reset();
    clr = 1'b1; src.delete(); drive();
    tick(); tick();
    clr = 1'b0; exp_q.delete();
  endtask

  task automatic drain();
    src.delete(); drive();
    pop_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (s_empty) break;
    end
    chk("drain_empty", int'(s_empty), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] fill_rw_addr [6];
    logic       fill_rw [6];
    logic [1:0] wrap_addr [6];
    logic [1:0] exp_err;
    int         wi;

    pop_ready = 1'b0;
    do_reset();

    // 1. reset state
    tick();
    chk("rst_count", int'(s_count), 0);
    chk("rst_empty", int'(s_empty), 1);
    chk("rst_full", int'(s_full), 0);
    chk("rst_pop_valid", int'(s_pv), 0);
    chk("rst_ram_rw", int'(s_rw), 0);
    chk("rst_ram_addr", int'(s_addr), 0);
    chk("rst_err", int'(s_err), 0);

    // 2. fill: W,R,W,W,W,W then F6 stalls
    fill_rw      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    fill_rw_addr = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    src = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    drive();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("fill_rw%0d", i), int'(s_rw), int'(fill_rw[i]));
      chk($sformatf("fill_addr%0d", i), int'(s_addr), int'(fill_rw_addr[i]));
    end
    tick();
    chk("full_push_ready", int'(s_pr), 0);
    chk("full_count", int'(s_count), 4);
    chk("full_flag", int'(s_full), 1);
    chk("full_pop_valid", int'(s_pv), 1);
    chk("full_pop_data", int'(s_pd), 8'hA1);

    // 3. drain on 5 consecutive cycles
    src.delete(); drive();
    pop_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("drain_pv%0d", i), int'(s_pv), 1);
    end
    tick();
    chk("drain_pop_valid", int'(s_pv), 0);
    chk("drain_empty", int'(s_empty), 1);
    chk("drain_sb_empty", exp_q.size(), 0);
    chk("drain_pops", n_pops, 5);

    // 4. contention with two words held
    pop_ready = 1'b0;
    src = '{8'h31, 8'h32, 8'h33};
    drive();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("pre_rw%0d", i), int'(s_rw), (i == 1) ? 0 : 1);
    end
    src = '{8'h34, 8'h35, 8'h36, 8'h37};
    drive();
    pop_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("cont_rw%0d", i), int'(s_rw), i % 2);
      chk($sformatf("cont_count%0d", i), int'(s_count), (i % 2 == 0) ? 2 : 1);
    end
    drain();
    chk("cont_sb_empty", exp_q.size(), 0);

    // 5. wrap-around
    do_reset();
    n_pops = 0;
    wrap_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    drive();
    pop_ready = 1'b1;
    wi = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (s_rw) begin
        if (wi < 6) chk($sformatf("wrap_addr%0d", wi), int'(s_addr), int'(wrap_addr[wi]));
        wi++;
      end
      if (src.size() == 0 && s_empty && !s_rw) break;
    end
    chk("wrap_writes", wi, 6);
    chk("wrap_pops", n_pops, 6);
    chk("wrap_sb_empty", exp_q.size(), 0);

    // 6a. clr during a write cycle
    pop_ready = 1'b0;
    src = '{8'h77, 8'h88};
    drive();
    for (int k = 0; k < 10; k++) begin
      if (src.size() == 0) break;
      tick();
    end
    src = '{8'h99};
    drive();
    clr = 1'b1;
    tick();
    prev_wrcnt = s_wrcnt;
    chk("clr_ram_rw", int'(s_rw), 0);
    chk("clr_push_ready", int'(s_pr), 0);
    clr = 1'b0;
    src.delete(); drive();
    exp_q.delete();
    tick();
    chk("clr_no_write", int'(s_wrcnt), int'(prev_wrcnt));
    chk("clr_count", int'(s_count), 0);
    chk("clr_pop_valid", int'(s_pv), 0);
    chk("clr_empty", int'(s_empty), 1);
    chk("clr_err", int'(s_err), 0);

    // 6b. overflow then underflow flags
    src = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    drive();
    for (int i = 0; i < 7; i++) tick();
    tick();
`ifdef RAM_FIFO_ERR_FLAGS_EN
    exp_err = 2'b01;
`else
    exp_err = 2'b00;
`endif
    chk("err_overflow", int'(s_err), int'(exp_err));
    chk("ovf_count", int'(s_count), 4);
    drain();
    tick();
`ifdef RAM_FIFO_ERR_FLAGS_EN
    exp_err = 2'b11;
`else
    exp_err = 2'b00;
`endif
    chk("err_underflow", int'(s_err), int'(exp_err));
    chk("flags_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
